dsp_fir_sequencer: RTL
======================

DSP_FIR_SEQUENCER -- requirements
Module: dsp_fir_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 4, number of FIR taps, legal range 1..16.
REQ-002 SHALL have parameter DSP_LAT, default 1, edges from an operand issue to the accumulated result appearing on dsp_z_i, legal range 1..4.
REQ-003 SHALL have ports, in this order:
- clock_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  4  tap index of the write.
- coef_data_i  in  18  signed coefficient.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  sample ready.
- s_data_i  in  20  signed sample.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  result ready.
- m_data_o  out  38  signed filter result.
- busy_o  out  1  high in any state other than IDLE.
- dsp_a_o  out  20  DSP multiplier operand a.
- dsp_b_o  out  18  DSP multiplier operand b.
- dsp_load_acc_o  out  1  DSP accumulator load: 1 = load product, 0 = add product to accumulator.
- dsp_feedback_o  out  3  tied to 3'b000.
- dsp_unsigned_a_o  out  1  tied to 0.
- dsp_unsigned_b_o  out  1  tied to 0.
- dsp_subtract_o  out  1  tied to 0.
- dsp_z_i  in  38  DSP accumulator output.

Function
REQ-004 SHALL hold NTAPS x 18-bit coefficient registers coef[0..NTAPS-1] and NTAPS x 20-bit delay-line registers x[0..NTAPS-1].
REQ-005 SHALL implement the FSM states IDLE, MAC, DRAIN and OUT.
REQ-006 In IDLE the block SHALL drive s_ready_o=1; in every other state s_ready_o SHALL be 0.
REQ-007 On a sample handshake (s_valid_i & s_ready_o), the block SHALL:
- shift the delay line, x[k] <= x[k-1] for k>=1 and x[0] <= s_data_i;
- set tap <= 0;
- go to MAC.
REQ-008 In each MAC cycle the block SHALL drive:
- dsp_a_o = x[tap];
- dsp_b_o = coef[tap];
- dsp_load_acc_o = (tap==0).
REQ-009 In MAC, tap SHALL increment by 1 each cycle; in the cycle with tap==NTAPS-1 the block SHALL go to DRAIN with drain counter = DSP_LAT-1. MAC lasts exactly NTAPS cycles.
REQ-010 Outside MAC the block SHALL drive dsp_a_o=0, dsp_b_o=0 and dsp_load_acc_o=0.
REQ-011 DRAIN SHALL last exactly DSP_LAT cycles, decrementing the counter each cycle.
REQ-012 At the edge ending the last DRAIN cycle the block SHALL capture m_data_o <= dsp_z_i, set m_valid_o=1 and go to OUT.
REQ-013 In OUT, m_valid_o and m_data_o SHALL hold stable until m_ready_i=1; on that edge the block SHALL clear m_valid_o and go to IDLE.
REQ-014 Sample-to-result latency SHALL be 1+NTAPS+DSP_LAT edges from the sample handshake to m_valid_o rising.
REQ-015 The minimum sample period SHALL be NTAPS+DSP_LAT+2 cycles with m_ready_i held at 1.
REQ-016 When coef_we_i=1 in IDLE and coef_addr_i<NTAPS, the block SHALL write coef[coef_addr_i] <= coef_data_i.
REQ-017 Coefficient writes in non-IDLE states or with coef_addr_i>=NTAPS SHALL be ignored, with no state change.
REQ-018 When coef_we_i and a sample handshake occur in the same IDLE cycle, the write SHALL take effect and the MAC sequence that follows SHALL use the new coefficient.
REQ-019 s_data_i SHALL be ignored when s_valid_i=0 or s_ready_o=0; the delay line SHALL shift only on a handshake.
REQ-020 The block SHALL perform no saturation or rounding; the result is the raw 38-bit dsp_z_i value.

Reset
REQ-021 While reset_i=1 at a clock edge, the block SHALL set state=IDLE, tap=0, drain counter=0, all x[k]=0, all coef[k]=0, m_valid_o=0 and m_data_o=0.
REQ-022 After reset the block SHALL show s_ready_o=1, busy_o=0 and dsp_load_acc_o=0 from the first cycle.
REQ-023 A reset asserted in MAC, DRAIN or OUT SHALL abort the sequence: no m_valid_o pulse and no partial result retained.
REQ-024 Reset SHALL take precedence over any simultaneous handshake or coefficient write.

Verification
REQ-025 The bench SHALL use a behavioural DSP model: at each edge, acc <= load_acc ? a*b : acc + a*b; dsp_z_i = acc, delayed so that DSP_LAT is honoured.
REQ-026 Scenario: NTAPS=4, DSP_LAT=1, coef = 1,2,3,4, samples 10, 20, 30, 40 -> results 10, 40, 100, 200, each with m_valid_o rising 6 edges after the sample handshake.
REQ-027 Scenario: m_ready_i held 0 for 5 cycles in OUT -> m_data_o stable, s_ready_o=0, a new s_valid_i is not accepted, the delay line is unchanged.
REQ-028 Scenario: coef_we_i in MAC writing coef[0]=7 -> ignored; the next result uses coef[0]=1. Write to coef_addr_i=5 in IDLE -> no register changes.
REQ-029 Scenario: reset_i pulsed in the second MAC cycle -> no m_valid_o. A subsequent sample 5 with coefficients reloaded to 1,2,3,4 -> result 5, confirming the delay line was cleared.
REQ-030 Scenario: NTAPS=1, DSP_LAT=3, coef[0]=-2, sample -100 -> m_data_o = 200 (38-bit signed), m_valid_o 5 edges after the handshake.

Source files
------------

// File: rtl/dsp_fir_sequencer.sv
// Time-multiplexed FIR sequencer that drives one external multiply-accumulate DSP slice.
// Latency: 1+NTAPS+DSP_LAT edges from the sample handshake to m_valid_o, counting the handshake edge as the first.
// Backpressure: one sample in flight; s_ready_o is high only in IDLE, and the result holds in OUT until m_ready_i.
//
// Ports:
//   clock_i, reset_i            : clock, synchronous active-high reset
//   coef_we_i/addr_i/data_i     : coefficient write port, honoured only in IDLE for addr < NTAPS
//   s_valid_i/s_ready_o/s_data_i: sample input handshake
//   m_valid_o/m_ready_i/m_data_o: filter result handshake (raw accumulator value)
//   busy_o                      : high in any state other than IDLE
//   dsp_*_o / dsp_z_i           : operand/control outputs to the DSP slice and its accumulator output
module dsp_fir_sequencer #(
    parameter int NTAPS   = 4,
    parameter int DSP_LAT = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        coef_we_i,
    input  logic [3:0]  coef_addr_i,
    input  logic [17:0] coef_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [19:0] s_data_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [37:0] m_data_o,
    output logic        busy_o,
    output logic [19:0] dsp_a_o,
    output logic [17:0] dsp_b_o,
    output logic        dsp_load_acc_o,
    output logic [2:0]  dsp_feedback_o,
    output logic        dsp_unsigned_a_o,
    output logic        dsp_unsigned_b_o,
    output logic        dsp_subtract_o,
    input  logic [37:0] dsp_z_i
);

    localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [TW-1:0] TAP_LAST   = TW'(NTAPS - 1);
    localparam logic [1:0]    DRAIN_INIT = 2'(DSP_LAT - 1);
    localparam logic [4:0]    NTAPS_L    = 5'(NTAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tap_q;
    logic [1:0]    drain_q;
    logic [17:0]   coef_q [NTAPS];
    logic [19:0]   x_q    [NTAPS];
    logic          m_valid_q;
    logic [37:0]   m_data_q;

    logic          idle;
    logic          in_mac;
    logic          coef_wr;
    logic [TW-1:0] coef_idx;

    assign idle     = (state_q == IDLE);
    assign in_mac   = (state_q == MAC);
    // Address check is done on the full 4-bit address so out-of-range writes
    // cannot alias onto a real tap through the truncated index below.
    assign coef_wr  = coef_we_i & idle & ({1'b0, coef_addr_i} < NTAPS_L);
    assign coef_idx = coef_addr_i[TW-1:0];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            drain_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            // Same-edge write and handshake: the write lands before the first
            // MAC cycle reads the coefficient, so the new value is used.
            if (coef_wr) begin
                coef_q[coef_idx] <= coef_data_i;
            end

            case (state_q)
                IDLE: begin
                    if (s_valid_i) begin
                        for (int k = NTAPS - 1; k >= 1; k--) begin
                            x_q[k] <= x_q[k-1];
                        end
                        x_q[0]  <= s_data_i;
                        tap_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (tap_q == TAP_LAST) begin
                        tap_q   <= '0;
                        drain_q <= DRAIN_INIT;
                        state_q <= DRAIN;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait out the DSP pipeline so the last product has reached dsp_z_i.
                    if (drain_q == 2'd0) begin
                        m_data_q  <= dsp_z_i;
                        m_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready_i) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready_o        = idle;
    assign busy_o           = ~idle;
    assign m_valid_o        = m_valid_q;
    assign m_data_o         = m_data_q;
    assign dsp_a_o          = in_mac ? x_q[tap_q]    : '0;
    assign dsp_b_o          = in_mac ? coef_q[tap_q] : '0;
    assign dsp_load_acc_o   = in_mac & (tap_q == '0);
    assign dsp_feedback_o   = 3'b000;
    assign dsp_unsigned_a_o = 1'b0;
    assign dsp_unsigned_b_o = 1'b0;
    assign dsp_subtract_o   = 1'b0;

endmodule
